// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared definitions for the peripheral bus: access size
//               encodings, byte-enable patterns and the initiator state type.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Access size encodings carried on cmd_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Byte-enable patterns; data is right-justified, so lanes start at bit 0
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } init_state_t;

  // Byte-enable for a given size; reserved size never reaches the bus
  function automatic logic [3:0] size_to_be(input logic [1:0] size);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = BE_BYTE;
      SZ_HALF: be = BE_HALF;
      SZ_WORD: be = BE_WORD;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_rdata_extend.sv
`default_nettype none
// ============================================================================
// Module      : bus_rdata_extend
// Description : Combinational size/sign extension of right-justified read
//               data. Shared by the bus initiator and the load unit.
// Ports       : i_rdata  - raw read data from the target
//               i_size   - access size (bus_pkg SZ_*)
//               i_signed - sign-extend byte/half reads
//               o_rdata  - extended read data
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rdata_extend
  import bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic w_sign_b;
  logic w_sign_h;

  assign w_sign_b = i_signed & i_rdata[7];
  assign w_sign_h = i_signed & i_rdata[15];

  always_comb begin
    o_rdata = i_rdata;
    case (i_size)
      SZ_BYTE: o_rdata = {{(DATA_WIDTH-8){w_sign_b}}, i_rdata[7:0]};
      SZ_HALF: o_rdata = {{(DATA_WIDTH-16){w_sign_h}}, i_rdata[15:0]};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bus_initiator.sv
`default_nettype none
// ============================================================================
// Module      : bus_initiator
// Description : Single-outstanding bus master. Accepts a read/write command,
//               holds the bus access until the target is ready (or a timeout
//               expires), then returns a response. All outputs except
//               cmd_ready are registered.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               cmd_*               - command channel (valid/ready)
//               rsp_*               - response channel (valid/ready)
//               bus_enable/wr_en/addr/wdata/be - drive the target
//               bus_ready/rdata/err - target responses
// Revision    : 1.0 - initial release
// ============================================================================
module bus_initiator
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [1:0]              cmd_size,
  input  logic                    cmd_signed,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    bus_enable,
  output logic                    bus_wr_en,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_wdata,
  output logic [DATA_WIDTH/8-1:0] bus_be,
  input  logic                    bus_ready,
  input  logic [DATA_WIDTH-1:0]   bus_rdata,
  input  logic                    bus_err
);

  localparam int                c_cnt_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  init_state_t                r_state,      w_state;
  logic [c_cnt_w-1:0]         r_cnt,        w_cnt;
  logic [1:0]                 r_size,       w_size;
  logic                       r_signed,     w_signed;
  logic                       r_bus_enable, w_bus_enable;
  logic                       r_bus_wr_en,  w_bus_wr_en;
  logic [ADDR_WIDTH-1:0]      r_bus_addr,   w_bus_addr;
  logic [DATA_WIDTH-1:0]      r_bus_wdata,  w_bus_wdata;
  logic [DATA_WIDTH/8-1:0]    r_bus_be,     w_bus_be;
  logic                       r_rsp_valid,  w_rsp_valid;
  logic [DATA_WIDTH-1:0]      r_rsp_rdata,  w_rsp_rdata;
  logic                       r_rsp_err,    w_rsp_err;
  logic                       r_rsp_timeout, w_rsp_timeout;

  logic [DATA_WIDTH-1:0]      w_ext_rdata;
  logic                       w_cmd_ready;

  bus_rdata_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_extend (
    .i_rdata  (bus_rdata),
    .i_size   (r_size),
    .i_signed (r_signed),
    .o_rdata  (w_ext_rdata)
  );

  // The target must have released ready from the previous access before a
  // new one starts, otherwise a stale ready would complete it immediately.
  assign w_cmd_ready = (r_state == IDLE) && !bus_ready;

  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_size        = r_size;
    w_signed      = r_signed;
    w_bus_enable  = r_bus_enable;
    w_bus_wr_en   = r_bus_wr_en;
    w_bus_addr    = r_bus_addr;
    w_bus_wdata   = r_bus_wdata;
    w_bus_be      = r_bus_be;
    w_rsp_valid   = r_rsp_valid;
    w_rsp_rdata   = r_rsp_rdata;
    w_rsp_err     = r_rsp_err;
    w_rsp_timeout = r_rsp_timeout;

    case (r_state)
      IDLE: begin
        if (cmd_valid && w_cmd_ready) begin
          if (cmd_size == SZ_RSVD) begin
            // Rejected without touching the bus
            w_rsp_valid   = 1'b1;
            w_rsp_err     = 1'b1;
            w_rsp_timeout = 1'b0;
            w_rsp_rdata   = '0;
            w_state       = RESPOND;
          end else begin
            w_size       = cmd_size;
            w_signed     = cmd_signed;
            w_bus_enable = 1'b1;
            w_bus_wr_en  = cmd_wr;
            w_bus_addr   = cmd_addr;
            w_bus_wdata  = cmd_wr ? cmd_wdata : '0;
            w_bus_be     = size_to_be(cmd_size);
            w_cnt        = '0;
            w_state      = ACCESS;
          end
        end
      end

      ACCESS: begin
        // ready is tested first so it wins over a coincident timeout
        if (bus_ready) begin
          w_bus_enable  = 1'b0;
          w_rsp_valid   = 1'b1;
          w_rsp_err     = bus_err;
          w_rsp_timeout = 1'b0;
          w_rsp_rdata   = (!r_bus_wr_en && !bus_err) ? w_ext_rdata : '0;
          w_state       = RESPOND;
        end else if (r_cnt == c_cnt_last) begin
          w_bus_enable  = 1'b0;
          w_rsp_valid   = 1'b1;
          w_rsp_err     = 1'b1;
          w_rsp_timeout = 1'b1;
          w_rsp_rdata   = '0;
          w_state       = RESPOND;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end

      RESPOND: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = IDLE;
        end
      end

      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_size        <= '0;
      r_signed      <= 1'b0;
      r_bus_enable  <= 1'b0;
      r_bus_wr_en   <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_wdata   <= '0;
      r_bus_be      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_size        <= w_size;
      r_signed      <= w_signed;
      r_bus_enable  <= w_bus_enable;
      r_bus_wr_en   <= w_bus_wr_en;
      r_bus_addr    <= w_bus_addr;
      r_bus_wdata   <= w_bus_wdata;
      r_bus_be      <= w_bus_be;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_rdata   <= w_rsp_rdata;
      r_rsp_err     <= w_rsp_err;
      r_rsp_timeout <= w_rsp_timeout;
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign bus_enable  = r_bus_enable;
  assign bus_wr_en   = r_bus_wr_en;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;
  assign bus_be      = r_bus_be;

endmodule
`default_nettype wire
